// File: rtl/dc_restore_tx.sv
// ---------------------------------------------------------------------------
// dc_restore_tx
// DAC-side DC re-insertion stage. Each accepted DC-free sample has the current
// offset added with saturation. The applied offset moves toward a programmable
// target by at most STEP per accepted sample, so retargeting never produces a
// step on the DAC.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         signed DC-free input sample
//   din_valid   input qualifier
//   din_ready   block can take din this cycle
//   dc_target   signed offset target, captured on dc_load
//   dc_load     one-cycle strobe that latches dc_target
//   dout        signed sat(din + offset), registered
//   dout_valid  dout qualifier
//   dout_ready  DAC side accepts dout
//   dc_offset   offset currently applied
//   ramping     offset is still moving toward the target
//   sat_cnt     saturated output samples, sticks at all-ones
// ---------------------------------------------------------------------------
module dc_restore_tx #(
    parameter int                    DATA_WIDTH    = 16,
    parameter logic [DATA_WIDTH-1:0] STEP          = 16'd4,
    parameter int                    SAT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic [DATA_WIDTH-1:0]    dc_target,
    input  logic                     dc_load,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [DATA_WIDTH-1:0]    dc_offset,
    output logic                     ramping,
    output logic [SAT_CNT_WIDTH-1:0] sat_cnt
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   next_state_s;
    logic [W-1:0]             dout_r;
    logic                     dout_valid_r;
    logic [W-1:0]             offset_r;
    logic [W-1:0]             target_r;
    logic                     ramping_r;
    logic [SAT_CNT_WIDTH-1:0] sat_cnt_r;

    logic                     accept_s;
    logic [W:0]               sum_s;
    logic                     sat_hi_s;
    logic                     sat_lo_s;
    logic [W-1:0]             sat_val_s;
    logic [W:0]               off_ext_s;
    logic [W:0]               diff_s;
    logic [W:0]               mag_s;
    logic [W:0]               step_amt_s;
    logic [W:0]               next_off_ext_s;
    logic [W-1:0]             next_offset_s;

    // Single output register: a slot frees up in the same cycle it drains.
    assign din_ready  = !dout_valid_r || dout_ready;
    assign accept_s   = din_valid && din_ready;

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign dc_offset  = offset_r;
    assign ramping    = ramping_r;
    assign sat_cnt    = sat_cnt_r;

    // Saturating add of the sample and the offset in effect before this accept.
    always_comb begin
        sum_s    = {din[W-1], din} + {offset_r[W-1], offset_r};
        // Top two bits disagree exactly when the W-bit result would wrap.
        sat_hi_s = (sum_s[W:W-1] == 2'b01);
        sat_lo_s = (sum_s[W:W-1] == 2'b10);
        if (sat_hi_s) begin
            sat_val_s = {1'b0, {(W-1){1'b1}}};
        end else if (sat_lo_s) begin
            sat_val_s = {1'b1, {(W-1){1'b0}}};
        end else begin
            sat_val_s = sum_s[W-1:0];
        end
    end

    // Bounded ramp step; W+1 bits keep full-scale target swings exact.
    always_comb begin
        off_ext_s = {offset_r[W-1], offset_r};
        diff_s    = {target_r[W-1], target_r} - off_ext_s;
        if (diff_s[W]) begin
            mag_s = ~diff_s + {{W{1'b0}}, 1'b1};
        end else begin
            mag_s = diff_s;
        end
        // Clamping to the remaining distance is what prevents overshoot.
        if (mag_s < {1'b0, STEP}) begin
            step_amt_s = mag_s;
        end else begin
            step_amt_s = {1'b0, STEP};
        end
        if (diff_s[W]) begin
            next_off_ext_s = off_ext_s - step_amt_s;
        end else begin
            next_off_ext_s = off_ext_s + step_amt_s;
        end
        next_offset_s = next_off_ext_s[W-1:0];
    end

    // Next ramp state; direction is re-derived from the sign of the distance on
    // every accept, so a retarget across the current offset reverses cleanly.
    always_comb begin
        next_state_s = ST_HOLD;
        case (state_r)
            ST_HOLD, ST_UP, ST_DOWN: begin
                if (next_offset_s == target_r) begin
                    next_state_s = ST_HOLD;
                end else if (diff_s[W]) begin
                    next_state_s = ST_DOWN;
                end else begin
                    next_state_s = ST_UP;
                end
            end
            default: begin
                next_state_s = ST_HOLD;
            end
        endcase
    end

    // Ramp FSM, output register and counters; all ramp state advances only on
    // accepted samples so an idle stream freezes the offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_HOLD;
            dout_r       <= {W{1'b0}};
            dout_valid_r <= 1'b0;
            offset_r     <= {W{1'b0}};
            target_r     <= {W{1'b0}};
            ramping_r    <= 1'b0;
            sat_cnt_r    <= {SAT_CNT_WIDTH{1'b0}};
        end else begin
            // A load coincident with an accept only affects later steps,
            // because this accept's step already used the old target.
            if (dc_load) begin
                target_r <= dc_target;
            end
            if (accept_s) begin
                dout_r       <= sat_val_s;
                dout_valid_r <= 1'b1;
                offset_r     <= next_offset_s;
                state_r      <= next_state_s;
                ramping_r    <= (next_state_s != ST_HOLD);
                if ((sat_hi_s || sat_lo_s) && (sat_cnt_r != {SAT_CNT_WIDTH{1'b1}})) begin
                    sat_cnt_r <= sat_cnt_r + {{(SAT_CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end else if (dout_ready) begin
                dout_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dc_restore_tx.sv
// ---------------------------------------------------------------------------
// tb_dc_restore_tx
// Self-checking bench for dc_restore_tx. A cycle-level reference model works
// on plain integers: offset moves toward target by min(4, distance) per
// accepted sample, outputs are the clamped integer sum.
// ---------------------------------------------------------------------------
module tb_dc_restore_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] dc_target;
    logic        dc_load;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [15:0] dc_offset;
    logic        ramping;
    logic [15:0] sat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_off;
    int          m_tgt;
    int          m_sat;
    logic [15:0] m_dout;
    bit          m_valid;
    bit          m_ramp;

    always #5 clk = ~clk;

    dc_restore_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dc_target  (dc_target),
        .dc_load    (dc_load),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dc_offset  (dc_offset),
        .ramping    (ramping),
        .sat_cnt    (sat_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_reset();
        m_off   = 0;
        m_tgt   = 0;
        m_sat   = 0;
        m_dout  = 16'h0000;
        m_valid = 1'b0;
        m_ramp  = 1'b0;
    endtask

    task automatic check_outputs(input string ctx);
        check_eq({ctx, ".dout"},       {16'h0000, dout},      {16'h0000, m_dout});
        check_eq({ctx, ".dout_valid"}, {31'd0, dout_valid},   {31'd0, m_valid});
        check_eq({ctx, ".dc_offset"},  {16'h0000, dc_offset}, {16'h0000, m_off[15:0]});
        check_eq({ctx, ".ramping"},    {31'd0, ramping},      {31'd0, m_ramp});
        check_eq({ctx, ".sat_cnt"},    {16'h0000, sat_cnt},   {16'h0000, m_sat[15:0]});
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input bit r,
                         input bit ld, input logic [15:0] t);
        din_valid  = v;
        din        = d;
        dout_ready = r;
        dc_load    = ld;
        dc_target  = t;
    endtask

    // One clock: check din_ready, advance the model across the edge, check outputs.
    task automatic step_cycle(input string ctx);
        bit acc;
        bit exp_ready;
        int s;
        int d;
        #1;
        exp_ready = !m_valid || dout_ready;
        check_eq({ctx, ".din_ready"}, {31'd0, din_ready}, {31'd0, exp_ready});
        acc = din_valid && exp_ready;
        @(posedge clk);
        if (acc) begin
            s = sx(din) + m_off;
            if (s > 32767) begin
                s = 32767;
                if (m_sat < 65535) m_sat++;
            end else if (s < -32768) begin
                s = -32768;
                if (m_sat < 65535) m_sat++;
            end
            m_dout = s[15:0];
            d = m_tgt - m_off;
            if (d > 0) m_off += (d < 4) ? d : 4;
            else if (d < 0) m_off -= (-d < 4) ? -d : 4;
            m_ramp  = (m_off != m_tgt);
            m_valid = 1'b1;
        end else if (dout_ready) begin
            m_valid = 1'b0;
        end
        if (dc_load) m_tgt = sx(dc_target);
        #1;
        check_outputs(ctx);
        dc_load = 1'b0;
    endtask

    task automatic run_stream(input string ctx, input int n, input logic [15:0] d);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, d, 1'b1, 1'b0, dc_target);
            step_cycle(ctx);
        end
    endtask

    initial begin
        logic [15:0] rt;
        int          sel;

        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pass-through with zero offset, full throughput.
        run_stream("pass", 10, 16'h0010);

        // Ramp 0 -> 0x10 with din = 0: dout 0,4,8,12,16,16...
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010);
        step_cycle("load10");
        run_stream("ramp_up", 7, 16'h0000);
        check_eq("ramp_up.final_dout", {16'h0000, dout}, 32'h0000_0010);

        // 0x10 -> 0x0E: single clipped step, then hold.
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h000E);
        step_cycle("load0e");
        run_stream("ramp_dn", 3, 16'h0000);
        check_eq("ramp_dn.final_off", {16'h0000, dc_offset}, 32'h0000_000E);

        // Ramp to 0x7FF0, then saturation checks.
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h7FF0);
        step_cycle("load7ff0");
        run_stream("ramp_big", 8200, 16'h0000);
        run_stream("sat_hi", 1, 16'h0100);
        check_eq("sat_hi.dout", {16'h0000, dout}, 32'h0000_7FFF);
        run_stream("no_sat", 1, 16'h8000);
        check_eq("no_sat.dout", {16'h0000, dout}, 32'h0000_FFF0);

        // Clipped approach to positive full scale, then full-scale reversal.
        drive(1'b1, 16'h0000, 1'b1, 1'b1, 16'h7FFF);
        step_cycle("load7fff");
        run_stream("to_max", 6, 16'h7000);
        drive(1'b1, 16'h8000, 1'b1, 1'b1, 16'h8000);
        step_cycle("load8000");
        run_stream("reverse", 20, 16'h8001);

        // Backpressure: 5 stalled cycles, din changing, then release.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, dc_target);
            step_cycle("stall");
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(16'h0200 + i), 1'b1, 1'b0, dc_target);
            step_cycle("release");
        end

        // Randomized traffic, retargets and extreme targets.
        for (int i = 0; i < 4000; i++) begin
            sel = int'($urandom_range(0, 9));
            rt  = 16'($urandom);
            if (sel == 0) rt = 16'h7FFF;
            else if (sel == 1) rt = 16'h8000;
            drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, rt);
            step_cycle("rand");
        end

        // Async reset mid-ramp with an output pending.
        drive(1'b1, 16'h0000, 1'b1, 1'b1, 16'h4000);
        step_cycle("pre_rst");
        run_stream("pre_rst", 3, 16'h1234);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        check_eq("pre_rst.valid", {31'd0, dout_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'h0005, 1'b1, 1'b0, 16'h0000);
        step_cycle("post_rst");
        check_eq("post_rst.dout", {16'h0000, dout}, 32'h0000_0005);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dc_restore_tx.md
Name: dc_restore_tx

Overview:
- DAC-side counterpart of the ADC DC-removal path.
- Takes DC-free signed samples and re-inserts a programmable DC offset with saturation.
- The applied offset slews toward a newly loaded target at a bounded rate, so target changes never produce a step on the DAC.
- Sits between the processing chain and the DAC interface; uses a valid/ready stream on both sides.

Parameters:
- DATA_WIDTH, 16, sample and offset width (signed two's complement).
- STEP, 16'd4, maximum offset change per accepted sample (unsigned, must be ≥1).
- SAT_CNT_WIDTH, 16, width of the saturation event counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DATA_WIDTH  signed DC-free sample.
- din_valid  in  1  din qualifier.
- din_ready  out  1  block can accept din this cycle.
- dc_target  in  DATA_WIDTH  signed offset target, sampled on dc_load.
- dc_load  in  1  one-cycle strobe; latches dc_target.
- dout  out  DATA_WIDTH  signed sat(din + offset) toward DAC.
- dout_valid  out  1  dout qualifier.
- dout_ready  in  1  DAC side accepts dout.
- dc_offset  out  DATA_WIDTH  currently applied offset.
- ramping  out  1  high while dc_offset != target.
- sat_cnt  out  SAT_CNT_WIDTH  count of saturated output samples, saturates at all-ones.

Behaviour:
- Reset (async assert, sync release):
  - dout = 0, dout_valid = 0, dc_offset = 0, target register = 0, ramping = 0, sat_cnt = 0.
  - FSM goes to HOLD.
- Handshake:
  - din_ready = !dout_valid || dout_ready (combinational; single output register, no bubble at full throughput).
  - A sample is accepted when din_valid && din_ready.
  - dout, dout_valid are registered; latency is 1 clock from acceptance to dout_valid.
  - When dout_valid && !dout_ready, dout must stay stable and din_ready = 0.
  - dout_valid falls only after a transfer with no new accept in the same cycle.
- Arithmetic:
  - sum = sign-extended din + sign-extended dc_offset, computed at DATA_WIDTH+1 bits.
  - If sum > 2^(W-1)-1, dout = 0x7FFF; if sum < -2^(W-1), dout = 0x8000; otherwise dout = sum.
  - dout uses the dc_offset value before that cycle's ramp update.
  - Each saturated accepted sample increments sat_cnt; sat_cnt holds at max.
- Target load:
  - On dc_load, the target register gets dc_target next cycle.
  - A dc_load during a ramp retargets immediately; the ramp continues from the current dc_offset (no jump).
  - dc_load in the same cycle as an accept: the sample uses the old offset, and the new target affects only subsequent steps.
- FSM (updates only on accepted samples; idle stream means offset frozen):
  - HOLD: offset == target. Go to UP if target > offset; go to DOWN if target < offset.
  - UP: offset += min(STEP, target - offset); go to HOLD on reaching target; go to DOWN if retargeted below offset.
  - DOWN: mirror of UP.
- Ramp arithmetic: difference is computed at W+1 bits so that extreme targets (0x7FFF ↔ 0x8000) neither overflow nor overshoot.
- ramping = (state != HOLD), registered.
- Reset mid-ramp or mid-stall: all state is cleared immediately and any pending dout is discarded.

Test Plan:
- Reset, then stream din = 0x0010 continuously, with dout_ready = 1 and no load → dout = 0x0010 one cycle after each accept; dc_offset = 0; ramping = 0; one sample per clock.
- dc_load with dc_target = 0x0010, STEP = 4, stream din = 0 → dout sequence 0, 4, 8, 12, 16, 16…; ramping falls on the cycle dc_offset reaches 0x0010.
- Ramp from offset 0x0010 to target 0x000E with STEP = 4 → single step to 0x000E, no overshoot; then HOLD.
- Offset at 0x7FF0 and din = 0x0100 → dout = 0x7FFF and sat_cnt increments by 1. Same offset with din = 0x8000 → dout = 0xFFF0, no saturation.
- Hold dout_ready = 0 for 5 cycles with din_valid = 1 → dout stable, din_ready = 0, dc_offset frozen. On release, the next sample appears without loss or duplication.
- Assert rst_n low mid-ramp while dout_valid = 1 → all outputs go to 0 asynchronously; after release, first accepted din = 0x0005 gives dout = 0x0005.
